bus_arbiter_mux: RTL and testbench
==================================

Name: bus_arbiter_mux

Overview:
- Successor to the combinational vector mux; arbitrates NUM_VECS requesters onto one shared VEC_BITS-wide bus.
- Adds request/grant/acknowledge handshaking with a held grant and a registered output.
- Supports fixed-priority or round-robin selection and an optional watchdog timeout.
- Sits between bus masters (CPU fetch/data ports, DMA) and the single slave-side bus of the SoC interconnect.

Parameters:
- NUM_VECS, 2: number of requesters; legal range ≥1.
- VEC_BITS, 32: width of each requester's vector.
- PRIORITY, 0: 1 selects fixed priority (lowest index wins); 0 selects round-robin.
- TIMEOUT, 0: maximum number of BUSY cycles without ack before a forced release; 0 disables the watchdog.

Ports:
- clk_i  input  1  system clock; all state changes on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  NUM_VECS  per-requester request, level-sensitive.
- vectors_i  input  NUM_VECS*VEC_BITS  flattened vectors; requester n occupies bits [(n+1)*VEC_BITS-1 : n*VEC_BITS].
- ack_i  input  1  downstream completion of the current transfer.
- grant_o  output  NUM_VECS  one-hot grant, registered.
- vector_o  output  VEC_BITS  winner's vector, registered.
- valid_o  output  1  high while a grant is held.
- timeout_o  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; grant_o=0, vector_o=0, valid_o=0, timeout_o=0.
  - rr_ptr=NUM_VECS-1, so the first round-robin grant goes to index 0.
  - Watchdog counter cleared.
- Two-state FSM, IDLE and BUSY.
- IDLE:
  - grant_o=0, valid_o=0, vector_o=0; ack_i is ignored.
  - If |req_i, the winner is chosen combinationally and BUSY is entered next edge: grant_o=onehot(winner), valid_o=1, vector_o=winner slice.
  - Latency from request to grant is one cycle.
- Winner selection:
  - PRIORITY=1: lowest set index.
  - PRIORITY=0: first set index searching upward from rr_ptr+1, wrapping modulo NUM_VECS. rr_ptr is loaded with the winner index on the IDLE->BUSY edge.
  - NUM_VECS=1: both modes reduce to grant = req_i[0].
- BUSY:
  - vector_o re-registers the granted slice every cycle, so it tracks the winner with one-cycle delay.
  - grant_o and the winner index are frozen; new or higher-priority requests never pre-empt.
- BUSY to IDLE, checked in priority order (first match wins):
  1. ack_i=1: release, normal completion.
  2. Granted req bit low: abort, no timeout pulse.
  3. TIMEOUT>0 and counter == TIMEOUT-1 with no ack: timeout_o=1 for exactly one cycle.
- On any release, grant_o, valid_o and vector_o are 0 on the next cycle.
- There is always at least one IDLE cycle between grants; back-to-back grants are not allowed.
- Watchdog counter:
  - Width $clog2(TIMEOUT+1).
  - Cleared on entering BUSY; increments each BUSY cycle; saturates, never wraps.
- Simultaneous events:
  - ack_i and timeout terminal count in the same cycle: treated as ack, no timeout pulse.
  - ack_i and request drop in the same cycle: treated as ack.
- Reset asserted mid-BUSY: outputs drop immediately (asynchronous). rr_ptr returns to NUM_VECS-1.
- Only the granted requester's slice ever reaches vector_o; other slices may change freely without effect.

Decomposition:
- Package arb_pkg holds:
  - the FSM state encoding (IDLE=1'b0, BUSY=1'b1);
  - the clog2-based counter-width function;
  - the onehot-to-index function.
- Sub-module rr_picker, combinational: inputs req, ptr, PRIORITY; outputs a one-hot winner and an index. Used once.
- Datapath slice selection reuses the existing one-hot OR-reduce mux, driven with the frozen grant.

Test Plan:
1. PRIORITY=1, NUM_VECS=4, req_i=4'b1010 -> grant_o=4'b0010 one cycle later, vector_o = slice 1. Ack, then req_i held -> after one IDLE cycle grant_o=4'b0010 again.
2. PRIORITY=0, req_i=4'b1111 held, ack each BUSY cycle -> grants 0001, 0010, 0100, 1000, 0001, each separated by one IDLE cycle.
3. TIMEOUT=4, req_i=4'b0001, no ack -> valid_o high 4 cycles, then timeout_o pulses once and grant_o=0. Same test with ack on the 4th cycle -> no timeout pulse.
4. Granted requester drops req while BUSY with no ack -> grant_o=0 next cycle, timeout_o stays 0, next pending requester granted after the IDLE cycle.
5. rst_ni pulled low mid-BUSY with vector_o=32'hDEADBEEF -> vector_o=0 and grant_o=0 asynchronously. After release, round-robin restarts at index 0.
6. While BUSY on index 2, higher-priority req_i[0] rises (PRIORITY=1) -> grant_o stays 4'b0100 until ack; index 0 is granted next.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and elaboration helpers for the bus arbiter/mux.
package arb_pkg;

    localparam int unsigned MAX_VECS = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Watchdog counter width; never narrower than one bit so the register exists.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned onehot_to_idx(input logic [MAX_VECS-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_VECS; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_mux_rr_picker.sv
// Combinational winner pick: lowest index (fixed priority) or first set
// index above the pointer with wrap (round-robin).
module rr_picker
    import arb_pkg::*;
#(
    parameter  int unsigned NUM_VECS = 2,
    parameter  int unsigned PRIORITY = 0,
    localparam int unsigned IDX_W    = idx_width(NUM_VECS)
) (
    input  logic [NUM_VECS-1:0] i_req,
    input  logic [IDX_W-1:0]    i_ptr,
    output logic [NUM_VECS-1:0] o_onehot,
    output logic [IDX_W-1:0]    o_idx
);

    // Smallest search distance wins; distance is the index itself in fixed-priority mode.
    always_comb begin
        int unsigned w_best;
        int unsigned w_dist;
        o_onehot = '0;
        w_best   = NUM_VECS;
        w_dist   = 0;
        for (int unsigned i = 0; i < NUM_VECS; i++) begin
            w_dist = (PRIORITY != 0) ? i
                   : (i + NUM_VECS - 1 - 32'(i_ptr)) % NUM_VECS;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
            end
        end
    end

    assign o_idx = IDX_W'(onehot_to_idx(MAX_VECS'(o_onehot)));

endmodule

// File: rtl/bus_arbiter_mux.sv
// Request/grant/ack arbiter that places one requester's vector on a shared
// registered bus, with held grants and an optional watchdog release.
module bus_arbiter_mux
    import arb_pkg::*;
#(
    parameter int unsigned NUM_VECS = 2,
    parameter int unsigned VEC_BITS = 32,
    parameter int unsigned PRIORITY = 0,
    parameter int unsigned TIMEOUT  = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_VECS-1:0]          req_i,
    input  logic [NUM_VECS*VEC_BITS-1:0] vectors_i,
    input  logic                         ack_i,
    output logic [NUM_VECS-1:0]          grant_o,
    output logic [VEC_BITS-1:0]          vector_o,
    output logic                         valid_o,
    output logic                         timeout_o
);

    localparam int unsigned IDX_W = idx_width(NUM_VECS);
    localparam int unsigned CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e            r_state;
    logic [NUM_VECS-1:0]   r_grant;
    logic [VEC_BITS-1:0]   r_vector;
    logic                  r_valid;
    logic                  r_timeout;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [CNT_W-1:0]      r_cnt;

    logic [NUM_VECS-1:0]   w_pick_oh;
    logic [IDX_W-1:0]      w_pick_idx;
    logic [NUM_VECS-1:0]   w_mux_sel;
    logic [VEC_BITS-1:0]   w_mux_vec;
    logic                  w_req_held;
    logic                  w_tmo_hit;

    rr_picker #(
        .NUM_VECS (NUM_VECS),
        .PRIORITY (PRIORITY)
    ) u_picker (
        .i_req    (req_i),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx)
    );

    // Select the fresh winner while idle, the frozen grant while busy.
    assign w_mux_sel  = (r_state == BUSY) ? r_grant : w_pick_oh;
    assign w_req_held = |(req_i & r_grant);
    assign w_tmo_hit  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_comb begin
        w_mux_vec = '0;
        for (int unsigned n = 0; n < NUM_VECS; n++) begin
            w_mux_vec = w_mux_vec
                      | (vectors_i[n*VEC_BITS +: VEC_BITS] & {VEC_BITS{w_mux_sel[n]}});
        end
    end

    // Release priority while busy: ack, then request drop, then watchdog.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_vector  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_rr_ptr  <= IDX_W'(NUM_VECS - 1);
            r_cnt     <= '0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state == IDLE) begin
                if (|req_i) begin
                    r_state  <= BUSY;
                    r_grant  <= w_pick_oh;
                    r_valid  <= 1'b1;
                    r_vector <= w_mux_vec;
                    r_rr_ptr <= w_pick_idx;
                    r_cnt    <= '0;
                end
            end else begin
                if (ack_i || !w_req_held || w_tmo_hit) begin
                    r_state   <= IDLE;
                    r_grant   <= '0;
                    r_valid   <= 1'b0;
                    r_vector  <= '0;
                    r_timeout <= !ack_i && w_req_held;
                end else begin
                    r_vector <= w_mux_vec;
                    if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign grant_o   = r_grant;
    assign vector_o  = r_vector;
    assign valid_o   = r_valid;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: a round-robin and a fixed-priority instance share
// stimulus and are checked every cycle against a transaction-level model.
module tb_bus_arbiter_mux;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int T_RR = 4;
    localparam int T_FP = 6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] vecs;
    logic           ack;

    logic [N-1:0] grant_rr, grant_fp;
    logic [W-1:0] vector_rr, vector_fp;
    logic         valid_rr, valid_fp, tmo_rr, tmo_fp;

    always #5 clk = ~clk;

    bus_arbiter_mux #(.NUM_VECS(N), .VEC_BITS(W), .PRIORITY(0), .TIMEOUT(T_RR)) dut_rr (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .vectors_i(vecs), .ack_i(ack),
        .grant_o(grant_rr), .vector_o(vector_rr), .valid_o(valid_rr), .timeout_o(tmo_rr)
    );

    bus_arbiter_mux #(.NUM_VECS(N), .VEC_BITS(W), .PRIORITY(1), .TIMEOUT(T_FP)) dut_fp (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .vectors_i(vecs), .ack_i(ack),
        .grant_o(grant_fp), .vector_o(vector_fp), .valid_o(valid_fp), .timeout_o(tmo_fp)
    );

    // Model: index 0 is the round-robin instance, index 1 the fixed-priority one.
    int           m_prio [2] = '{0, 1};
    int           m_tlim [2] = '{T_RR, T_FP};
    bit           m_busy [2];
    int           m_owner[2];
    int           m_cnt  [2];
    int           m_ptr  [2];
    bit           m_tmo  [2];
    logic [W-1:0] m_vec  [2];

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    function automatic int pick(input int prio, input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (prio != 0) ? k : (ptr + 1 + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_grant(input int d);
        logic [N-1:0] g;
        g = '0;
        if (m_busy[d]) g[m_owner[d]] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d]  = 1'b0;
            m_owner[d] = 0;
            m_cnt[d]   = 0;
            m_ptr[d]   = N - 1;
            m_tmo[d]   = 1'b0;
            m_vec[d]   = '0;
        end
    endtask

    // One clock edge of the arbitration rules, using the inputs seen at that edge.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            m_tmo[d] = 1'b0;
            if (!m_busy[d]) begin
                m_vec[d] = '0;
                if (req != '0) begin
                    m_owner[d] = pick(m_prio[d], req, m_ptr[d]);
                    m_ptr[d]   = m_owner[d];
                    m_busy[d]  = 1'b1;
                    m_cnt[d]   = 0;
                    m_vec[d]   = vecs[m_owner[d]*W +: W];
                end
            end else begin
                if (ack) begin
                    m_busy[d] = 1'b0;
                end else if (!req[m_owner[d]]) begin
                    m_busy[d] = 1'b0;
                end else if (m_tlim[d] > 0 && m_cnt[d] == m_tlim[d] - 1) begin
                    m_busy[d] = 1'b0;
                    m_tmo[d]  = 1'b1;
                end else begin
                    m_cnt[d] = m_cnt[d] + 1;
                    m_vec[d] = vecs[m_owner[d]*W +: W];
                end
                if (!m_busy[d]) m_vec[d] = '0;
            end
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("grant_rr",  W'(grant_rr),  W'(exp_grant(0)));
            check("vector_rr", vector_rr,     m_vec[0]);
            check("valid_rr",  W'(valid_rr),  W'(m_busy[0]));
            check("tmo_rr",    W'(tmo_rr),    W'(m_tmo[0]));
            check("grant_fp",  W'(grant_fp),  W'(exp_grant(1)));
            check("vector_fp", vector_fp,     m_vec[1]);
            check("valid_fp",  W'(valid_fp),  W'(m_busy[1]));
            check("tmo_fp",    W'(tmo_fp),    W'(m_tmo[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Reset asserted mid-cycle; outputs must fall without waiting for a clock.
    task automatic async_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        check({tag, "_grant_rr"},  W'(grant_rr), '0);
        check({tag, "_vector_rr"}, vector_rr,    '0);
        check({tag, "_valid_rr"},  W'(valid_rr), '0);
        check({tag, "_grant_fp"},  W'(grant_fp), '0);
        check({tag, "_vector_fp"}, vector_fp,    '0);
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic flush();
        ack = 1'b1;
        req = '0;
        tick();
        tick();
        ack = 1'b0;
    endtask

    logic [N-1:0] seq [9];

    initial begin
        rst_n = 1'b1;
        req   = '0;
        ack   = 1'b0;
        vecs  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst_grant_rr", W'(grant_rr), '0);
        check("rst_vector_rr", vector_rr, '0);
        check("rst_valid_fp", W'(valid_fp), '0);
        check("rst_tmo_fp", W'(tmo_fp), '0);
        chk_en = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Fixed priority picks index 1 from 1010; same requester regranted after an idle cycle.
        req = 4'b1010;
        tick();
        check("t1_grant_fp", W'(grant_fp), 32'h2);
        check("t1_vector_fp", vector_fp, 32'h2222_2222);
        check("t1_grant_rr", W'(grant_rr), 32'h2);
        ack = 1'b1;
        tick();
        check("t1_release_fp", W'(grant_fp), '0);
        ack = 1'b0;
        tick();
        check("t1_regrant_fp", W'(grant_fp), 32'h2);
        check("t1_regrant_rr", W'(grant_rr), 32'h8);
        flush();

        // Mid-busy reset with a known vector on the bus.
        vecs[2*W +: W] = 32'hDEAD_BEEF;
        req = 4'b0100;
        tick();
        check("t5_vector_rr", vector_rr, 32'hDEAD_BEEF);
        async_reset("t5");

        // Round-robin rotation after reset, acking every busy cycle.
        seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
        req = 4'b1111;
        ack = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("t2_grant_rr_%0d", i), W'(grant_rr), W'(seq[i]));
        end
        flush();

        // Watchdog: four busy cycles then a single timeout pulse.
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t3_valid_rr_%0d", i), W'(valid_rr), 32'h1);
        end
        tick();
        check("t3_tmo_rr", W'(tmo_rr), 32'h1);
        check("t3_grant_rr", W'(grant_rr), '0);
        tick();
        check("t3_tmo_clear_rr", W'(tmo_rr), '0);
        check("t3_regrant_rr", W'(valid_rr), 32'h1);
        tick();
        tick();
        tick();
        ack = 1'b1;
        tick();
        check("t3_ack_tmo_rr", W'(tmo_rr), '0);
        check("t3_ack_valid_rr", W'(valid_rr), '0);
        ack = 1'b0;
        req = '0;
        tick();
        check("t3_ack_tmo2_rr", W'(tmo_rr), '0);
        flush();

        // Granted requester drops: abort without pulse, next requester follows.
        req = 4'b0011;
        tick();
        check("t4_grant_fp", W'(grant_fp), 32'h1);
        req = 4'b0010;
        tick();
        check("t4_abort_fp", W'(grant_fp), '0);
        check("t4_tmo_fp", W'(tmo_fp), '0);
        tick();
        check("t4_next_fp", W'(grant_fp), 32'h2);
        flush();

        // No pre-emption by a higher-priority request.
        req = 4'b0100;
        tick();
        check("t6_grant_fp", W'(grant_fp), 32'h4);
        req = 4'b0101;
        tick();
        check("t6_hold1_fp", W'(grant_fp), 32'h4);
        tick();
        check("t6_hold2_fp", W'(grant_fp), 32'h4);
        ack = 1'b1;
        tick();
        check("t6_release_fp", W'(grant_fp), '0);
        ack = 1'b0;
        tick();
        check("t6_next_fp", W'(grant_fp), 32'h1);
        flush();

        // Randomised traffic: sticky requests, sparse acks, churning vectors.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) req[b] = ~req[b];
                vecs[b*W +: W] = $urandom();
            end
            ack = ($urandom_range(3) == 0);
            tick();
            if (c % 1000 == 999) async_reset("rnd_rst");
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
